// File: rtl/wb_scoreboard_pkg.sv
// Shared types and constants for the write-back scoreboard.
// Holds the checker state encoding and the default counter width.
package wb_scoreboard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_TIMEOUT = 2'd2
   } sb_state_e;

   localparam int DEF_CNT_SIZE = 16;

endpackage

// File: rtl/wb_scoreboard_exp_fifo.sv
// Synchronous FIFO of expected {addr,data} write-backs.
// Its count carries one extra bit so that full and empty can be told apart.
module exp_fifo #(
   parameter int Width = 37,
   parameter int Depth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         wdata_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic [Width-1:0]         head_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      count_d = count_q + CntW'(1);
         else if (!do_push && do_pop) count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset: only entries below count are ever read as valid.
   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/wb_scoreboard.sv
// Write-back checker: compares each core register-file write with the head of a
// queue of expected writes, counts results, captures the first error, detects stalls.
module wb_scoreboard
   import wb_scoreboard_pkg::*;
#(
   parameter int DataSize      = 32,
   parameter int RegAddrSize   = 5,
   parameter int ExpDepth      = 16,
   parameter int TimeoutCycles = 64,
   parameter int CntSize       = DEF_CNT_SIZE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      check_en,
   input  logic                      exp_valid,
   output logic                      exp_ready,
   input  logic [RegAddrSize-1:0]    exp_addr,
   input  logic [DataSize-1:0]       exp_data,
   input  logic                      wb_en,
   input  logic [RegAddrSize-1:0]    wb_addr,
   input  logic [DataSize-1:0]       wb_data,
   output logic [CntSize-1:0]        match_num,
   output logic [CntSize-1:0]        err_num,
   output logic                      mismatch,
   output logic [RegAddrSize-1:0]    mm_addr,
   output logic [DataSize-1:0]       mm_got,
   output logic [DataSize-1:0]       mm_exp,
   output logic                      timeout,
   output logic                      done,
   output logic [$clog2(ExpDepth):0] fifo_count
);

   localparam int EntW = RegAddrSize + DataSize;
   localparam int TmrW = $clog2(TimeoutCycles + 1);
   localparam logic [TmrW-1:0]    TmrLim = TmrW'(TimeoutCycles);
   localparam logic [CntSize-1:0] CntMax = '1;

   sb_state_e              state_q, state_d;
   logic [TmrW-1:0]        timer_q, timer_d;
   logic [CntSize-1:0]     match_q, match_d, err_q, err_d;
   logic                   mismatch_q, mismatch_d, first_q, first_d;
   logic [RegAddrSize-1:0] mm_addr_q, mm_addr_d;
   logic [DataSize-1:0]    mm_got_q, mm_got_d, mm_exp_q, mm_exp_d;

   logic            full, empty, push, pop, wb_act, hit;
   logic [EntW-1:0] head;

   function automatic logic [CntSize-1:0] sat_inc(input logic [CntSize-1:0] v);
      return (v == CntMax) ? v : v + CntSize'(1);
   endfunction

   // Readiness comes from registered state only, so a same-cycle pop never frees a slot.
   assign exp_ready = !full && (state_q != ST_TIMEOUT);
   assign push      = exp_valid && exp_ready && !clear;
   assign wb_act    = (state_q == ST_RUN) && check_en && wb_en;
   assign pop       = wb_act && !empty && !clear;
   assign hit       = (head == {wb_addr, wb_data});

   exp_fifo #(
      .Width (EntW),
      .Depth (ExpDepth)
   ) u_exp_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({exp_addr, exp_data}),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count),
      .head_o  (head)
   );

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      match_d    = match_q;
      err_d      = err_q;
      mismatch_d = 1'b0;
      first_d    = first_q;
      mm_addr_d  = mm_addr_q;
      mm_got_d   = mm_got_q;
      mm_exp_d   = mm_exp_q;
      if (clear) begin
         state_d   = ST_IDLE;
         timer_d   = '0;
         match_d   = '0;
         err_d     = '0;
         first_d   = 1'b0;
         mm_addr_d = '0;
         mm_got_d  = '0;
         mm_exp_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_d = '0;
               if (check_en) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!check_en) begin
                  state_d = ST_IDLE;
                  timer_d = '0;
               end else if (wb_en || empty) begin
                  timer_d = '0;
               end else if (timer_q + TmrW'(1) == TmrLim) begin
                  timer_d = TmrLim;
                  state_d = ST_TIMEOUT;
               end else begin
                  timer_d = timer_q + TmrW'(1);
               end
            end
            ST_TIMEOUT: ;
            default: state_d = ST_IDLE;
         endcase
         if (wb_act) begin
            if (!empty && hit) begin
               match_d = sat_inc(match_q);
            end else begin
               err_d      = sat_inc(err_q);
               mismatch_d = 1'b1;
               if (!first_q) begin
                  first_d   = 1'b1;
                  mm_addr_d = wb_addr;
                  mm_got_d  = wb_data;
                  mm_exp_d  = empty ? '0 : head[DataSize-1:0];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         match_q    <= '0;
         err_q      <= '0;
         mismatch_q <= 1'b0;
         first_q    <= 1'b0;
         mm_addr_q  <= '0;
         mm_got_q   <= '0;
         mm_exp_q   <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         match_q    <= match_d;
         err_q      <= err_d;
         mismatch_q <= mismatch_d;
         first_q    <= first_d;
         mm_addr_q  <= mm_addr_d;
         mm_got_q   <= mm_got_d;
         mm_exp_q   <= mm_exp_d;
      end
   end

   assign match_num = match_q;
   assign err_num   = err_q;
   assign mismatch  = mismatch_q;
   assign mm_addr   = mm_addr_q;
   assign mm_got    = mm_got_q;
   assign mm_exp    = mm_exp_q;
   assign timeout   = (state_q == ST_TIMEOUT);
   assign done      = (state_q == ST_RUN) && empty;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the scoreboard rules.
module tb_wb_scoreboard;

   localparam int DW = 32, AW = 5, DEPTH = 16, TO = 12, CW = 4;
   localparam int FW = $clog2(DEPTH) + 1;

   logic clk = 1'b0, reset = 1'b0, clear = 1'b0, check_en = 1'b0;
   logic exp_valid = 1'b0, wb_en = 1'b0;
   logic [AW-1:0] exp_addr = '0, wb_addr = '0;
   logic [DW-1:0] exp_data = '0, wb_data = '0;
   logic          exp_ready, mismatch, timeout, done;
   logic [CW-1:0] match_num, err_num;
   logic [AW-1:0] mm_addr;
   logic [DW-1:0] mm_got, mm_exp;
   logic [FW-1:0] fifo_count;

   int checks = 0, errors = 0;

   // Reference model: 0=idle, 1=run, 2=timeout
   logic [AW+DW-1:0] mq[$];
   int               m_state, m_timer;
   logic [CW-1:0]    m_match, m_err;
   bit               m_mm, m_first;
   logic [AW-1:0]    m_mmaddr;
   logic [DW-1:0]    m_mmgot, m_mmexp;

   wb_scoreboard #(
      .DataSize(DW), .RegAddrSize(AW), .ExpDepth(DEPTH),
      .TimeoutCycles(TO), .CntSize(CW)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .check_en(check_en),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr),
      .exp_data(exp_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .match_num(match_num), .err_num(err_num), .mismatch(mismatch),
      .mm_addr(mm_addr), .mm_got(mm_got), .mm_exp(mm_exp),
      .timeout(timeout), .done(done), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic m_reset();
      mq.delete();
      m_state = 0; m_timer = 0; m_match = '0; m_err = '0;
      m_mm = 0; m_first = 0; m_mmaddr = '0; m_mmgot = '0; m_mmexp = '0;
   endtask

   task automatic m_error(input logic [DW-1:0] expd);
      if (m_err != '1) m_err = m_err + 1'b1;
      m_mm = 1;
      if (!m_first) begin
         m_first = 1; m_mmaddr = wb_addr; m_mmgot = wb_data; m_mmexp = expd;
      end
   endtask

   // Advance one clock: apply the rules to the model, then sample #1 after the edge.
   task automatic cyc();
      logic [AW+DW-1:0] h;
      bit rdy, wb, was_empty;
      int st;
      if (clear) begin
         m_reset();
      end else begin
         st = m_state;
         was_empty = (mq.size() == 0);
         rdy = (mq.size() < DEPTH) && (st != 2);
         wb = (st == 1) && check_en && wb_en;
         m_mm = 0;
         if (wb) begin
            if (was_empty) m_error('0);
            else begin
               h = mq.pop_front();
               if (h == {wb_addr, wb_data}) begin
                  if (m_match != '1) m_match = m_match + 1'b1;
               end else m_error(h[DW-1:0]);
            end
         end
         if (exp_valid && rdy) mq.push_back({exp_addr, exp_data});
         if (st == 0) begin
            m_timer = 0;
            if (check_en) m_state = 1;
         end else if (st == 1) begin
            if (!check_en) begin m_state = 0; m_timer = 0; end
            else if (wb || was_empty) m_timer = 0;
            else begin
               m_timer++;
               if (m_timer >= TO) m_state = 2;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({match_num, err_num, mismatch, timeout, done, fifo_count} !== '0 || exp_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got m=%0d e=%0d mm=%0b to=%0b dn=%0b cnt=%0d rdy=%0b required zeros rdy=1",
                  match_num, err_num, mismatch, timeout, done, fifo_count, exp_ready);
      end
      #3 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_clear();
      clear = 1'b1; check_en = 1'b0; exp_valid = 1'b0; wb_en = 1'b0;
      cyc();
      clear = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_valid = 1'b1; exp_addr = a; exp_data = d;
      cyc();
      exp_valid = 1'b0;
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      cyc();
      wb_en = 1'b0;
   endtask

   task automatic test_in_order();
      logic [DW-1:0] vals [3] = '{32'h00C8, 32'h012C, 32'h01F4};
      bit saw_mm = 0;
      do_clear();
      for (int i = 0; i < 3; i++) push(AW'(i), vals[i]);
      checks++;
      if (fifo_count !== FW'(3)) begin
         errors++; $display("FAIL inorder_count: got %0d required 3", fifo_count);
      end
      check_en = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         write(AW'(i), vals[i]);
         if (mismatch) saw_mm = 1;
         repeat (3) begin cyc(); if (mismatch) saw_mm = 1; end
      end
      checks++;
      if (match_num !== 4'd3 || err_num !== 4'd0 || done !== 1'b1 || saw_mm) begin
         errors++;
         $display("FAIL inorder_result: got m=%0d e=%0d done=%0b mm_seen=%0b required 3 0 1 0",
                  match_num, err_num, done, saw_mm);
      end
   endtask

   task automatic test_mismatch();
      do_clear();
      push(AW'(2), 32'h0064);
      check_en = 1'b1;
      cyc();
      write(AW'(2), 32'h0065);
      checks++;
      if (err_num !== 4'd1 || mismatch !== 1'b1 || mm_addr !== AW'(2) ||
          mm_got !== 32'h65 || mm_exp !== 32'h64) begin
         errors++;
         $display("FAIL mismatch_capture: got e=%0d mm=%0b a=%0d g=%0h x=%0h required 1 1 2 65 64",
                  err_num, mismatch, mm_addr, mm_got, mm_exp);
      end
      cyc();
      checks++;
      if (mismatch !== 1'b0) begin
         errors++; $display("FAIL mismatch_pulse: got %0b required 0", mismatch);
      end
      write(AW'(7), 32'h1234);
      checks++;
      if (err_num !== 4'd2 || mm_addr !== AW'(2) || mm_got !== 32'h65 || mm_exp !== 32'h64) begin
         errors++;
         $display("FAIL mismatch_freeze: got e=%0d a=%0d g=%0h x=%0h required 2 2 65 64",
                  err_num, mm_addr, mm_got, mm_exp);
      end
   endtask

   task automatic test_unexpected();
      do_clear();
      check_en = 1'b1;
      cyc();
      write(AW'(9), 32'h0280);
      checks++;
      if (err_num !== 4'd1 || mismatch !== 1'b1 || mm_addr !== AW'(9) ||
          mm_got !== 32'h280 || mm_exp !== '0) begin
         errors++;
         $display("FAIL unexpected_write: got e=%0d mm=%0b a=%0d g=%0h x=%0h required 1 1 9 280 0",
                  err_num, mismatch, mm_addr, mm_got, mm_exp);
      end
      check_en = 1'b0;
      cyc();
      write(AW'(9), 32'h0280);
      checks++;
      if (err_num !== 4'd1 || mismatch !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL unexpected_disabled: got e=%0d mm=%0b done=%0b required 1 0 0", err_num, mismatch, done);
      end
   endtask

   task automatic test_full();
      logic [DW-1:0] d0;
      do_clear();
      d0 = $urandom;
      push(AW'(0), d0);
      for (int i = 1; i < DEPTH; i++) push(AW'(i), $urandom);
      checks++;
      if (exp_ready !== 1'b0 || fifo_count !== FW'(DEPTH)) begin
         errors++; $display("FAIL full_state: got rdy=%0b cnt=%0d required 0 %0d", exp_ready, fifo_count, DEPTH);
      end
      check_en = 1'b1;
      cyc();
      exp_valid = 1'b1; exp_addr = AW'(31); exp_data = 32'hABCD;
      write(AW'(0), d0);
      checks++;
      if (fifo_count !== FW'(DEPTH - 1) || match_num !== 4'd1 || exp_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_simul: got cnt=%0d m=%0d rdy=%0b required %0d 1 1", fifo_count, match_num, exp_ready, DEPTH - 1);
      end
      exp_valid = 1'b1;
      cyc();
      exp_valid = 1'b0;
      checks++;
      if (fifo_count !== FW'(DEPTH) || exp_ready !== 1'b0) begin
         errors++; $display("FAIL full_refill: got cnt=%0d rdy=%0b required %0d 0", fifo_count, exp_ready, DEPTH);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      do_clear();
      push(AW'(4), 32'h55);
      check_en = 1'b1;
      cyc();
      while (timeout !== 1'b1 && n < TO + 8) begin cyc(); n++; end
      checks++;
      if (n != TO || exp_ready !== 1'b0) begin
         errors++; $display("FAIL timeout_latency: got %0d cycles rdy=%0b required %0d 0", n, exp_ready, TO);
      end
      exp_valid = 1'b1;
      write(AW'(4), 32'h55);
      exp_valid = 1'b0;
      checks++;
      if (match_num !== 4'd0 || err_num !== 4'd0 || fifo_count !== FW'(1) || timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_ignore: got m=%0d e=%0d cnt=%0d to=%0b required 0 0 1 1", match_num, err_num, fifo_count, timeout);
      end
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      checks++;
      if (timeout !== 1'b0 || exp_ready !== 1'b1 || fifo_count !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: got to=%0b rdy=%0b cnt=%0d done=%0b required 0 1 0 0", timeout, exp_ready, fifo_count, done);
      end
      check_en = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid();
      do_clear();
      for (int i = 0; i < 5; i++) push(AW'(i), 32'h100 + i);
      check_en = 1'b1;
      cyc();
      write(AW'(0), 32'hDEAD);
      write(AW'(1), 32'hBEEF);
      checks++;
      if (err_num !== 4'd2 || fifo_count !== FW'(3)) begin
         errors++; $display("FAIL midreset_setup: got e=%0d cnt=%0d required 2 3", err_num, fifo_count);
      end
      #2 reset = 1'b0;
      #1;
      m_reset();
      checks++;
      if ({match_num, err_num, mismatch, timeout, done, fifo_count, mm_addr, mm_got, mm_exp} !== '0 ||
          exp_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_async: got e=%0d cnt=%0d dn=%0b a=%0d g=%0h rdy=%0b required zeros rdy=1",
                  err_num, fifo_count, done, mm_addr, mm_got, exp_ready);
      end
      check_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [AW+DW-1:0] h;
      do_clear();
      for (int c = 0; c < 1500; c++) begin
         clear     = ($urandom_range(0, 99) == 0);
         check_en  = ($urandom_range(0, 19) != 0);
         exp_valid = ($urandom_range(0, 99) < 45);
         exp_addr  = AW'($urandom);
         exp_data  = $urandom_range(0, 3);
         wb_en     = ($urandom_range(0, 99) < 35);
         if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
            h = mq[0];
            wb_addr = h[AW+DW-1:DW]; wb_data = h[DW-1:0];
         end else begin
            wb_addr = AW'($urandom); wb_data = $urandom_range(0, 3);
         end
         cyc();
         checks++;
         if ({exp_ready, mismatch, timeout, done, fifo_count, match_num, err_num} !==
             {(mq.size() < DEPTH) && (m_state != 2), m_mm, m_state == 2,
              (m_state == 1) && (mq.size() == 0), FW'(mq.size()), m_match, m_err}) begin
            errors++;
            $display("FAIL random_ctrl cyc %0d: got rdy=%0b mm=%0b to=%0b dn=%0b cnt=%0d m=%0d e=%0d required cnt=%0d m=%0d e=%0d mm=%0b st=%0d",
                     c, exp_ready, mismatch, timeout, done, fifo_count, match_num, err_num,
                     mq.size(), m_match, m_err, m_mm, m_state);
         end
         checks++;
         if ({mm_addr, mm_got, mm_exp} !== {m_mmaddr, m_mmgot, m_mmexp}) begin
            errors++;
            $display("FAIL random_capture cyc %0d: got %0d/%0h/%0h required %0d/%0h/%0h",
                     c, mm_addr, mm_got, mm_exp, m_mmaddr, m_mmgot, m_mmexp);
         end
      end
      clear = 1'b0; check_en = 1'b0; exp_valid = 1'b0; wb_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_mismatch();
      test_unexpected();
      test_full();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
